gate_reduce_pipe: RTL

GATE_REDUCE_PIPE -- requirements
Module: gate_reduce_pipe

---
 rtl/gate_pkg.sv | 15 +
 rtl/gate_reduce_lane.sv | 25 ++
 rtl/gate_reduce_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Gate op-codes and the legal-op check shared by the reduction pipeline and its lanes.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_reduce_lane.sv
// One result bit: the selected gate folded across the same bit of every input word.
module gate_reduce_lane
  import gate_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [2:0]        op,
  input  logic [NUM_IN-1:0] bits,
  output logic              result
);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = &bits;
      OP_OR:   result = |bits;
      OP_XOR:  result = ^bits;
      OP_NAND: result = ~&bits;
      OP_NOR:  result = ~|bits;
      OP_XNOR: result = ~^bits;
      default: result = 1'b0;  // illegal ops reduce to zero
    endcase
  end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline reducing NUM_IN words under a selectable gate,
// with an illegal-op flag and a saturating accepted-beat counter.
module gate_reduce_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 4,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_op_err,
  output logic [COUNT_W-1:0]        beat_count
);

  logic                     s1_valid_reg;
  logic [2:0]               s1_op_reg;
  logic [NUM_IN*WIDTH-1:0]  s1_data_reg;
  logic                     s2_valid_reg;
  logic [WIDTH-1:0]         s2_data_reg;
  logic                     s2_err_reg;
  logic [COUNT_W-1:0]       beat_count_reg;

  logic                     s2_can_load;
  logic                     in_accept;
  logic [WIDTH-1:0]         reduce_next;
  logic                     err_next;

  // in_ready depends only on registered state and out_ready, never on in_valid
  assign s2_can_load = !s2_valid_reg || out_ready;
  assign in_ready    = !s1_valid_reg || s2_can_load;
  assign in_accept   = in_valid && in_ready;
  assign err_next    = !is_legal_op(s1_op_reg);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic [NUM_IN-1:0] lane_bits;
      for (genvar gk = 0; gk < NUM_IN; gk++) begin : g_word
        assign lane_bits[gk] = s1_data_reg[gk*WIDTH + gi];
      end
      gate_reduce_lane #(.NUM_IN(NUM_IN)) u_lane (
        .op     (s1_op_reg),
        .bits   (lane_bits),
        .result (reduce_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_data_reg  <= '0;
    end else if (in_ready) begin
      // S1 either empties into S2 this edge or was already empty
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_op_reg   <= in_op;
        s1_data_reg <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= reduce_next;
        s2_err_reg  <= err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_reg <= '0;
    end else if (in_accept && (beat_count_reg != {COUNT_W{1'b1}})) begin
      beat_count_reg <= beat_count_reg + COUNT_W'(1);
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_data   = s2_data_reg;
  assign out_op_err = s2_err_reg;
  assign beat_count = beat_count_reg;

endmodule
